manycore_link_tieoff_sink: RTL and testbench

- Terminates an unused manycore mesh edge or IO link port so traffic reaching it cannot deadlock the network.
- Accepts every forward request and returns a canned response to its source.
- Absorbs every reverse packet.
- Counts traffic and raises a sticky error, since any traffic here means a mis-addressed packet.

---
 rtl/manycore_link_tieoff_sink.sv | 103 ++++++++++
 tb/tb_manycore_link_tieoff_sink.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/manycore_link_tieoff_sink.sv
// manycore_link_tieoff_sink: terminates an unused mesh/IO link, answering requests with canned responses
// and absorbing reverse traffic while counting it and flagging a sticky error.
module manycore_link_tieoff_sink #(
    parameter int addr_width_p    = 28,
    parameter int data_width_p    = 32,
    parameter int x_cord_width_p  = 4,
    parameter int y_cord_width_p  = 5,
    parameter int resp_fifo_els_p = 2,
    parameter logic [data_width_p-1:0] load_data_p = 32'hDEAD_BEEF,
    localparam int FW = addr_width_p + 11 + data_width_p + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int RW = 7 + data_width_p + x_cord_width_p + y_cord_width_p
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    fwd_v_i,
    input  logic [FW-1:0]           fwd_data_i,
    output logic                    fwd_ready_o,
    input  logic                    rev_v_i,
    input  logic [RW-1:0]           rev_data_i,
    output logic                    rev_ready_o,
    output logic                    fwd_v_o,
    output logic [FW-1:0]           fwd_data_o,
    output logic                    rev_v_o,
    output logic [RW-1:0]           rev_data_o,
    input  logic                    rev_ready_i,
    output logic [31:0]             fwd_count_o,
    output logic [31:0]             rev_count_o,
    output logic                    error_o,
    output logic [addr_width_p-1:0] first_addr_o
);
    localparam int XW = x_cord_width_p;
    localparam int YW = y_cord_width_p;
    localparam int SX_LSB = XW + YW;
    localparam int SY_LSB = 2 * XW + YW;
    localparam int RG_LSB = 2 * (XW + YW) + data_width_p;
    localparam int OP_LSB = RG_LSB + 9;
    localparam int AD_LSB = RG_LSB + 11;
    localparam int PW = resp_fifo_els_p > 1 ? $clog2(resp_fifo_els_p) : 1;
    localparam int CW = $clog2(resp_fifo_els_p + 1);

    logic [RW-1:0] mem_q [resp_fifo_els_p];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] fwd_count_q, fwd_count_d, rev_count_q, rev_count_d;
    logic error_q, error_d;
    logic [addr_width_p-1:0] first_addr_q, first_addr_d;
    logic [1:0] op;
    logic [RW-1:0] resp;
    logic fwd_acc, rev_acc, enq, deq;

    assign op          = fwd_data_i[OP_LSB +: 2];
    assign fwd_ready_o = reset_n_i & (cnt_q != CW'(resp_fifo_els_p));
    assign rev_ready_o = reset_n_i;
    assign fwd_acc     = fwd_v_i & fwd_ready_o;
    assign rev_acc     = rev_v_i & rev_ready_o;
    assign enq         = fwd_acc & (op != 2'b11);
    assign deq         = rev_v_o & rev_ready_i;
    assign resp        = {op, op == 2'b00 ? '0 : load_data_p, fwd_data_i[RG_LSB +: 5],
                          fwd_data_i[SY_LSB +: YW], fwd_data_i[SX_LSB +: XW]};
    assign rev_v_o      = cnt_q != '0;
    assign rev_data_o   = mem_q[rd_ptr_q];
    assign fwd_v_o      = 1'b0;
    assign fwd_data_o   = '0;
    assign fwd_count_o  = fwd_count_q;
    assign rev_count_o  = rev_count_q;
    assign error_o      = error_q;
    assign first_addr_o = first_addr_q;

    always_comb begin
        wr_ptr_d     = enq ? (wr_ptr_q == PW'(resp_fifo_els_p - 1) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d     = deq ? (rd_ptr_q == PW'(resp_fifo_els_p - 1) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
        cnt_d        = cnt_q + CW'(enq) - CW'(deq);
        fwd_count_d  = (fwd_acc && fwd_count_q != '1) ? fwd_count_q + 32'd1 : fwd_count_q;
        rev_count_d  = (rev_acc && rev_count_q != '1) ? rev_count_q + 32'd1 : rev_count_q;
        error_d      = error_q | fwd_acc | rev_acc;
        first_addr_d = (fwd_acc && !error_q) ? fwd_data_i[AD_LSB +: addr_width_p] : first_addr_q;
    end

    // storage needs no reset: the occupancy count alone defines what is valid
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= resp;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            fwd_count_q  <= '0;
            rev_count_q  <= '0;
            error_q      <= 1'b0;
            first_addr_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            fwd_count_q  <= fwd_count_d;
            rev_count_q  <= rev_count_d;
            error_q      <= error_d;
            first_addr_q <= first_addr_d;
        end
    end
endmodule

// File: tb/tb_manycore_link_tieoff_sink.sv
// tb_manycore_link_tieoff_sink: directed plus random traffic checked against a queue-based model.
module tb_manycore_link_tieoff_sink;
    localparam int AW = 28;
    localparam int FW = 89;
    localparam int RW = 48;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fwd_v = 1'b0;
    logic [FW-1:0] fwd_data = '0;
    logic rev_v_in = 1'b0;
    logic [RW-1:0] rev_data_in = '0;
    logic rev_ready = 1'b0;
    logic fwd_ready_o, rev_ready_o, fwd_v_o, rev_v_o, error_o;
    logic [FW-1:0] fwd_data_o;
    logic [RW-1:0] rev_data_o;
    logic [31:0] fwd_count_o, rev_count_o;
    logic [AW-1:0] first_addr_o;

    manycore_link_tieoff_sink dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .fwd_v_i(fwd_v), .fwd_data_i(fwd_data), .fwd_ready_o(fwd_ready_o),
        .rev_v_i(rev_v_in), .rev_data_i(rev_data_in), .rev_ready_o(rev_ready_o),
        .fwd_v_o(fwd_v_o), .fwd_data_o(fwd_data_o),
        .rev_v_o(rev_v_o), .rev_data_o(rev_data_o), .rev_ready_i(rev_ready),
        .fwd_count_o(fwd_count_o), .rev_count_o(rev_count_o),
        .error_o(error_o), .first_addr_o(first_addr_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [RW-1:0] mq[$];
    logic [31:0] m_fcnt, m_rcnt;
    logic m_err;
    logic [AW-1:0] m_first;
    logic [1:0] cur_op;
    logic [4:0] cur_rg, cur_sy;
    logic [3:0] cur_sx;
    logic [AW-1:0] cur_addr;
    logic [RW-1:0] hold;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(logic [AW-1:0] a, logic [1:0] op, logic [4:0] rg, logic [3:0] sx, logic [4:0] sy);
        cur_addr = a; cur_op = op; cur_rg = rg; cur_sx = sx; cur_sy = sy;
        fwd_data = {a, op, 4'($urandom), rg, 32'($urandom), sy, sx, 5'($urandom), 4'($urandom)};
        fwd_v = 1'b1;
    endtask

    function automatic logic [31:0] sat(logic [31:0] c);
        return c == 32'hFFFF_FFFF ? c : c + 32'd1;
    endfunction

    task automatic check_all();
        check("fwd_ready", fwd_ready_o, mq.size() < DEPTH);
        check("rev_ready", rev_ready_o, 1'b1);
        check("rev_v", rev_v_o, mq.size() > 0);
        if (mq.size() > 0) check("rev_data", rev_data_o, mq[0]);
        check("fwd_count", fwd_count_o, m_fcnt);
        check("rev_count", rev_count_o, m_rcnt);
        check("error", error_o, m_err);
        check("first_addr", first_addr_o, m_first);
        check("fwd_v_o", fwd_v_o, 1'b0);
        check("fwd_data_o", fwd_data_o, '0);
    endtask

    task automatic step();
        bit af, ar, dq;
        af = fwd_v && mq.size() < DEPTH;
        ar = rev_v_in;
        dq = mq.size() > 0 && rev_ready;
        @(posedge clk); #1;
        if (dq) void'(mq.pop_front());
        if (af && cur_op != 2'd3)
            mq.push_back({cur_op, cur_op == 2'd0 ? 32'h0 : 32'hDEAD_BEEF, cur_rg, cur_sy, cur_sx});
        if (af) m_fcnt = sat(m_fcnt);
        if (ar) m_rcnt = sat(m_rcnt);
        if (af && !m_err) m_first = cur_addr;
        if (af || ar) m_err = 1'b1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rev_v", rev_v_o, 1'b0);
        check("rst_fwd_ready", fwd_ready_o, 1'b0);
        check("rst_rev_ready", rev_ready_o, 1'b0);
        check("rst_fwd_count", fwd_count_o, 32'd0);
        check("rst_rev_count", rev_count_o, 32'd0);
        check("rst_error", error_o, 1'b0);
        check("rst_first_addr", first_addr_o, '0);
        mq.delete();
        m_fcnt = '0; m_rcnt = '0; m_err = 1'b0; m_first = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_all();
    endtask

    initial begin
        #2;
        do_reset();
        // load from (x=2,y=1) reg 5
        rev_ready = 1'b0;
        send(28'h123_4567, 2'd1, 5'd5, 4'd2, 5'd1);
        step();
        fwd_v = 1'b0;
        check("load_resp", rev_data_o, {2'd1, 32'hDEAD_BEEF, 5'd5, 5'd1, 4'd2});
        check("load_v", rev_v_o, 1'b1);
        check("load_first", first_addr_o, 28'h123_4567);
        rev_ready = 1'b1;
        step();
        // back-pressure with three stores
        do_reset();
        rev_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send(28'($urandom), 2'd0, 5'(i + 1), 4'(i), 5'(i + 3));
            step();
        end
        check("full_ready", fwd_ready_o, 1'b0);
        hold = rev_data_o;
        send(28'($urandom), 2'd0, 5'd9, 4'd7, 5'd6);
        step();
        step();
        check("hold_stable", rev_data_o, hold);
        check("full_count", fwd_count_o, 32'd2);
        rev_ready = 1'b1;
        step();
        step();
        fwd_v = 1'b0;
        repeat (3) step();
        check("drain_count", fwd_count_o, 32'd3);
        // op 11 gets no response
        do_reset();
        send(28'h0ab_cdef, 2'd3, 5'd4, 4'd1, 5'd2);
        step();
        fwd_v = 1'b0;
        step();
        check("op3_v", rev_v_o, 1'b0);
        check("op3_count", fwd_count_o, 32'd1);
        // reverse traffic first blocks address capture
        do_reset();
        rev_v_in = 1'b1;
        repeat (3) begin
            rev_data_in = RW'({$urandom, $urandom});
            step();
        end
        rev_v_in = 1'b0;
        check("rev_count3", rev_count_o, 32'd3);
        send(28'h555_5555, 2'd2, 5'd3, 4'd3, 5'd3);
        step();
        fwd_v = 1'b0;
        step();
        check("rev_first_blocked", first_addr_o, '0);
        // saturation
        force dut.fwd_count_q = 32'hFFFF_FFFE;
        m_fcnt = 32'hFFFF_FFFE;
        step();
        release dut.fwd_count_q;
        send(28'($urandom), 2'd1, 5'd1, 4'd1, 5'd1);
        step();
        step();
        fwd_v = 1'b0;
        step();
        check("sat_count", fwd_count_o, 32'hFFFF_FFFF);
        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1, 0) == 1)
                send(28'($urandom), 2'($urandom), 5'($urandom), 4'($urandom), 5'($urandom));
            else
                fwd_v = 1'b0;
            rev_v_in = $urandom_range(3, 0) == 0;
            rev_data_in = RW'({$urandom, $urandom});
            rev_ready = $urandom_range(1, 0) == 1;
            step();
        end
        fwd_v = 1'b0; rev_v_in = 1'b0;
        // async reset with two queued responses
        do_reset();
        rev_ready = 1'b0;
        repeat (2) begin
            send(28'($urandom), 2'd1, 5'($urandom), 4'($urandom), 5'($urandom));
            step();
        end
        fwd_v = 1'b0;
        check("pre_reset_v", rev_v_o, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_rev_v", rev_v_o, 1'b0);
        do_reset();
        rev_ready = 1'b1;
        repeat (3) step();
        check("no_stale", rev_v_o, 1'b0);
        check("post_error", error_o, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
